// File: rtl/hub75_scheduler.sv
// HUB75 frame/row/bit-plane sequencer: drives streamer requests, latch/OE/row
// with binary-coded modulation, and the led_mem buffer swap at frame boundaries.
module hub75_scheduler #(
    parameter int unsigned NR_ROWS        = 16,
    parameter int unsigned NR_BITPLANES   = 8,
    parameter int unsigned BASE_OE_CYCLES = 8,
    parameter int unsigned BLANK_CYCLES   = 2,
    localparam int unsigned RW = (NR_ROWS > 1) ? $clog2(NR_ROWS) : 1,
    localparam int unsigned PW = (NR_BITPLANES > 1) ? $clog2(NR_BITPLANES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          swap_req,
    output logic          swap_done,
    output logic          disp_buf,
    output logic          stream_start,
    output logic [RW-1:0] stream_row,
    output logic [PW-1:0] stream_plane,
    input  logic          stream_done,
    output logic [RW-1:0] phy_row,
    output logic          phy_lat,
    output logic          phy_oe_n,
    output logic          busy,
    output logic [15:0]   frame_cnt
);

    localparam int unsigned TW = $clog2(BASE_OE_CYCLES << (NR_BITPLANES - 1)) + 1;
    localparam int unsigned BW = $clog2(BLANK_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, START, SHIFT, WAIT_OE, BLANK, LATCH} state_t;

    state_t        state, state_d;
    logic [TW-1:0] oe_timer, oe_timer_d;
    logic [BW-1:0] blank_cnt, blank_cnt_d;
    logic          swap_pending, swap_pending_d;
    logic          stopping, stopping_d;
    logic [RW-1:0] row_d;
    logic [PW-1:0] plane_d;
    logic          disp_buf_d, swap_done_d;
    logic [15:0]   frame_cnt_d;
    logic          last_plane, last_row, frame_end;

    // stream_row/stream_plane double as the step pointer
    assign last_plane = (stream_plane == PW'(NR_BITPLANES - 1));
    assign last_row   = (stream_row == RW'(NR_ROWS - 1));
    assign frame_end  = last_plane && last_row;

    always_comb begin
        state_d        = state;
        oe_timer_d     = (oe_timer != '0) ? oe_timer - TW'(1) : oe_timer;
        blank_cnt_d    = blank_cnt;
        swap_pending_d = swap_pending | swap_req;
        stopping_d     = stopping;
        row_d          = stream_row;
        plane_d        = stream_plane;
        disp_buf_d     = disp_buf;
        swap_done_d    = 1'b0;
        frame_cnt_d    = frame_cnt;
        unique case (state)
            IDLE:    if (enable) state_d = START;
            START:   state_d = SHIFT;
            SHIFT:   if (stream_done) state_d = WAIT_OE;
            WAIT_OE: begin
                if (oe_timer == '0) begin
                    blank_cnt_d = '0;
                    if (stopping) begin
                        state_d    = IDLE;
                        stopping_d = 1'b0;
                    end else begin
                        state_d = BLANK;
                    end
                end
            end
            BLANK: begin
                blank_cnt_d = blank_cnt + BW'(1);
                if (blank_cnt == BW'(BLANK_CYCLES - 1)) state_d = LATCH;
            end
            LATCH: begin
                oe_timer_d = TW'(BASE_OE_CYCLES) << stream_plane;
                state_d    = START;
                if (last_plane) begin
                    plane_d = '0;
                    row_d   = last_row ? '0 : stream_row + RW'(1);
                end else begin
                    plane_d = stream_plane + PW'(1);
                end
                // frame boundary: count, swap buffers, and honour a stop request
                if (frame_end) begin
                    frame_cnt_d = frame_cnt + 16'd1;
                    if (swap_pending || swap_req) begin
                        disp_buf_d     = ~disp_buf;
                        swap_done_d    = 1'b1;
                        swap_pending_d = 1'b0;
                    end
                    if (!enable) begin
                        state_d    = WAIT_OE;
                        stopping_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            oe_timer     <= '0;
            blank_cnt    <= '0;
            swap_pending <= 1'b0;
            stopping     <= 1'b0;
            stream_row   <= '0;
            stream_plane <= '0;
            disp_buf     <= 1'b0;
            swap_done    <= 1'b0;
            frame_cnt    <= '0;
            stream_start <= 1'b0;
            phy_lat      <= 1'b0;
            phy_row      <= '0;
            phy_oe_n     <= 1'b1;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            oe_timer     <= oe_timer_d;
            blank_cnt    <= blank_cnt_d;
            swap_pending <= swap_pending_d;
            stopping     <= stopping_d;
            stream_row   <= row_d;
            stream_plane <= plane_d;
            disp_buf     <= disp_buf_d;
            swap_done    <= swap_done_d;
            frame_cnt    <= frame_cnt_d;
            stream_start <= (state_d == START);
            phy_lat      <= (state_d == LATCH);
            if (state_d == LATCH) phy_row <= stream_row;
            phy_oe_n     <= (oe_timer_d == '0) || (state_d inside {IDLE, BLANK, LATCH});
            busy         <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_hub75_scheduler.sv
// Directed bench for hub75_scheduler: 2 rows, 2 planes, base OE 4, blank 2,
// with a streamer model answering stream_start after a programmable delay.
module tb_hub75_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        swap_req = 1'b0;
    logic        spur_done = 1'b0;
    logic        model_done = 1'b0;
    logic        stream_done;
    logic        swap_done, disp_buf, stream_start, phy_lat, phy_oe_n, busy;
    logic [0:0]  stream_row, stream_plane, phy_row;
    logic [15:0] frame_cnt;

    assign stream_done = model_done | spur_done;

    hub75_scheduler #(
        .NR_ROWS(2), .NR_BITPLANES(2), .BASE_OE_CYCLES(4), .BLANK_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .swap_req(swap_req),
        .swap_done(swap_done), .disp_buf(disp_buf), .stream_start(stream_start),
        .stream_row(stream_row), .stream_plane(stream_plane), .stream_done(stream_done),
        .phy_row(phy_row), .phy_lat(phy_lat), .phy_oe_n(phy_oe_n), .busy(busy),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int lat_cyc[$], lat_row[$], lat_plane[$], runs[$];
    int start_cyc[$], start_buf[$], start_row[$], start_plane[$];
    int swap_cyc[$], fc_cyc[$], done_cyc[$];
    int lat_oe_bad = 0, run = 0, fc_prev = 0, sd_cnt = 0;
    int sd_delay = 10;
    int errors = 0, checks = 0;
    int b_lat, b_run, b_start, b_swap, b_fc, b_done, en_cyc;

    // event recorder plus streamer model, sampled mid-cycle
    always @(negedge clk) begin
        if (!phy_oe_n) run = run + 1;
        else if (run != 0) begin runs.push_back(run); run = 0; end
        if (phy_lat) begin
            lat_cyc.push_back(cyc); lat_row.push_back(int'(phy_row));
            lat_plane.push_back(int'(stream_plane));
            if (!phy_oe_n) lat_oe_bad = lat_oe_bad + 1;
        end
        if (stream_start) begin
            start_cyc.push_back(cyc); start_buf.push_back(int'(disp_buf));
            start_row.push_back(int'(stream_row)); start_plane.push_back(int'(stream_plane));
        end
        if (swap_done) swap_cyc.push_back(cyc);
        if (int'(frame_cnt) != fc_prev) begin fc_cyc.push_back(cyc); fc_prev = int'(frame_cnt); end
        model_done = 1'b0;
        if (sd_cnt != 0) begin
            sd_cnt = sd_cnt - 1;
            if (sd_cnt == 0) model_done = 1'b1;
        end
        if (stream_start) sd_cnt = sd_delay;
        if (model_done) done_cyc.push_back(cyc);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic snap();
        b_lat = lat_cyc.size(); b_run = runs.size(); b_start = start_cyc.size();
        b_swap = swap_cyc.size(); b_fc = fc_cyc.size(); b_done = done_cyc.size();
    endtask

    task automatic do_reset();
        enable = 1'b0; swap_req = 1'b0; spur_done = 1'b0;
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        cycles(15);
    endtask

    task automatic test_reset();
        cycles(2);
        checks++; if (phy_oe_n !== 1'b1) begin errors++; $display("FAIL reset_oe_n: got %b want 1", phy_oe_n); end
        checks++; if ({phy_lat, stream_start, swap_done, busy, disp_buf} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {phy_lat, stream_start, swap_done, busy, disp_buf}); end
        checks++; if ({phy_row, stream_row, stream_plane} !== 3'b0) begin
            errors++; $display("FAIL reset_ptr: got %b want 000", {phy_row, stream_row, stream_plane}); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        reset = 1'b0;
        cycles(3);
        snap();
        spur_done = 1'b1; cycles(1); spur_done = 1'b0;
        cycles(3);
        checks++; if (busy !== 1'b0 || start_cyc.size() != b_start) begin
            errors++; $display("FAIL idle_done_ignored: busy=%b starts=%0d want 0/%0d", busy, start_cyc.size(), b_start); end
    endtask

    task automatic test_first_frame();
        int exp_run[4] = '{4, 8, 4, 8};
        int exp_row[4] = '{0, 0, 1, 1};
        do_reset(); sd_delay = 10; snap();
        enable = 1'b1; en_cyc = cyc;
        for (int i = 0; i < 200 && runs.size() < b_run + 4; i++) cycles(1);
        checks++; if (runs.size() < b_run + 4) begin errors++; $display("FAIL first_timeout: runs=%0d want %0d", runs.size() - b_run, 4); end
        checks++; if (start_cyc[b_start] != en_cyc + 1) begin
            errors++; $display("FAIL start_latency: got %0d want %0d", start_cyc[b_start] - en_cyc, 1); end
        checks++; if (start_row[b_start] != 0 || start_plane[b_start] != 0) begin
            errors++; $display("FAIL first_step: got row%0d/plane%0d want row0/plane0", start_row[b_start], start_plane[b_start]); end
        checks++; if (lat_cyc[b_lat] - done_cyc[b_done] != 4) begin
            errors++; $display("FAIL done_to_lat: got %0d want 4", lat_cyc[b_lat] - done_cyc[b_done]); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (runs[b_run + k] != exp_run[k]) begin
                errors++; $display("FAIL oe_run%0d: got %0d want %0d", k, runs[b_run + k], exp_run[k]); end
            checks++; if (lat_row[b_lat + k] != exp_row[k]) begin
                errors++; $display("FAIL phy_row%0d: got %0d want %0d", k, lat_row[b_lat + k], exp_row[k]); end
        end
    endtask

    task automatic test_free_run();
        do_reset(); sd_delay = 10; snap();
        enable = 1'b1;
        for (int i = 0; i < 400 && frame_cnt != 16'd3; i++) cycles(1);
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL frame_cnt3: got %0d want 3", frame_cnt); end
        for (int f = 0; f < 3; f++) begin
            checks++; if (fc_cyc[b_fc + f] != lat_cyc[b_lat + 4*f + 3] + 1) begin
                errors++; $display("FAIL fc_step%0d: got cyc %0d want %0d", f, fc_cyc[b_fc + f], lat_cyc[b_lat + 4*f + 3] + 1); end
            checks++; if (lat_row[b_lat + 4*f + 3] != 1 || lat_plane[b_lat + 4*f + 3] != 1) begin
                errors++; $display("FAIL boundary_step%0d: got row%0d/plane%0d want row1/plane1", f,
                                   lat_row[b_lat + 4*f + 3], lat_plane[b_lat + 4*f + 3]); end
        end
        checks++; if (lat_oe_bad != 0) begin errors++; $display("FAIL oe_during_lat: got %0d want 0", lat_oe_bad); end
    endtask

    task automatic test_swap();
        int i;
        do_reset(); sd_delay = 10; snap();
        enable = 1'b1;
        cycles(20); swap_req = 1'b1; cycles(1); swap_req = 1'b0;
        cycles(10); swap_req = 1'b1; cycles(1); swap_req = 1'b0;
        for (i = 0; i < 200 && frame_cnt != 16'd1; i++) cycles(1);
        cycles(2);
        checks++; if (swap_cyc.size() != b_swap + 1) begin
            errors++; $display("FAIL swap_count: got %0d want 1", swap_cyc.size() - b_swap); end
        checks++; if (swap_cyc[b_swap] != lat_cyc[b_lat + 3] + 1) begin
            errors++; $display("FAIL swap_time: got cyc %0d want %0d", swap_cyc[b_swap], lat_cyc[b_lat + 3] + 1); end
        checks++; if (start_buf[b_start + 3] != 0 || start_buf[b_start + 4] != 1) begin
            errors++; $display("FAIL swap_buf: got %0d,%0d want 0,1", start_buf[b_start + 3], start_buf[b_start + 4]); end
        // request arriving in the boundary LATCH itself
        for (i = 0; i < 200 && !(phy_lat && frame_cnt == 16'd1 && stream_row == 1'b1 && stream_plane == 1'b1); i++) cycles(1);
        swap_req = 1'b1; cycles(1); swap_req = 1'b0;
        cycles(2);
        checks++; if (swap_cyc.size() != b_swap + 2 || disp_buf !== 1'b0) begin
            errors++; $display("FAIL boundary_swap: swaps=%0d buf=%b want 2/0", swap_cyc.size() - b_swap, disp_buf); end
        checks++; if (start_buf[b_start + 8] != 0) begin
            errors++; $display("FAIL boundary_buf: got %0d want 0", start_buf[b_start + 8]); end
    endtask

    task automatic test_short_shift();
        int exp_run[4] = '{4, 8, 4, 8};
        do_reset(); sd_delay = 2; snap();
        enable = 1'b1;
        for (int i = 0; i < 200 && runs.size() < b_run + 4; i++) cycles(1);
        for (int k = 0; k < 4; k++) begin
            checks++; if (runs[b_run + k] != exp_run[k]) begin
                errors++; $display("FAIL short_run%0d: got %0d want %0d", k, runs[b_run + k], exp_run[k]); end
        end
        checks++; if (done_cyc[b_done + 1] - lat_cyc[b_lat] != 3) begin
            errors++; $display("FAIL short_done: got %0d want 3", done_cyc[b_done + 1] - lat_cyc[b_lat]); end
        checks++; if (lat_cyc[b_lat + 1] - lat_cyc[b_lat] != 8) begin
            errors++; $display("FAIL short_gap1: got %0d want 8", lat_cyc[b_lat + 1] - lat_cyc[b_lat]); end
        checks++; if (lat_cyc[b_lat + 2] - lat_cyc[b_lat + 1] != 12) begin
            errors++; $display("FAIL short_gap2: got %0d want 12", lat_cyc[b_lat + 2] - lat_cyc[b_lat + 1]); end
        sd_delay = 10;
    endtask

    task automatic test_stop();
        do_reset(); sd_delay = 10; snap();
        enable = 1'b1;
        for (int i = 0; i < 200 && frame_cnt != 16'd1; i++) cycles(1);
        enable = 1'b0;
        for (int i = 0; i < 200 && lat_cyc.size() < b_lat + 8; i++) cycles(1);
        checks++; if (lat_cyc.size() != b_lat + 8) begin
            errors++; $display("FAIL stop_lats: got %0d want 8", lat_cyc.size() - b_lat); end
        cycles(5);
        checks++; if (busy !== 1'b1 || phy_oe_n !== 1'b0) begin
            errors++; $display("FAIL stop_drain: busy=%b oe_n=%b want 1/0", busy, phy_oe_n); end
        cycles(7);
        checks++; if (busy !== 1'b0 || phy_oe_n !== 1'b1 || frame_cnt !== 16'd2) begin
            errors++; $display("FAIL stop_idle: busy=%b oe_n=%b frames=%0d want 0/1/2", busy, phy_oe_n, frame_cnt); end
        checks++; if (runs[b_run + 7] != 8) begin errors++; $display("FAIL stop_last_run: got %0d want 8", runs[b_run + 7]); end
        cycles(30);
        checks++; if (start_cyc.size() != b_start + 8 || busy !== 1'b0) begin
            errors++; $display("FAIL stop_quiet: starts=%0d busy=%b want 8/0", start_cyc.size() - b_start, busy); end
    endtask

    task automatic test_reset_mid();
        do_reset(); sd_delay = 10; snap();
        enable = 1'b1;
        for (int i = 0; i < 200 && !(phy_lat && stream_row == 1'b1 && stream_plane == 1'b1); i++) cycles(1);
        cycles(1);
        checks++; if (phy_oe_n !== 1'b0 || stream_start !== 1'b1) begin
            errors++; $display("FAIL overlap: oe_n=%b start=%b want 0/1", phy_oe_n, stream_start); end
        #1 reset = 1'b1;
        #1;
        checks++; if (phy_oe_n !== 1'b1 || phy_lat !== 1'b0 || stream_start !== 1'b0) begin
            errors++; $display("FAIL async_reset: oe_n=%b lat=%b start=%b want 1/0/0", phy_oe_n, phy_lat, stream_start); end
        enable = 1'b0;
        cycles(2);
        reset = 1'b0;
        snap();
        spur_done = 1'b1; cycles(1); spur_done = 1'b0;
        cycles(15);
        checks++; if (busy !== 1'b0 || start_cyc.size() != b_start || done_cyc.size() != b_done + 1) begin
            errors++; $display("FAIL post_reset_idle: busy=%b starts=%0d dones=%0d want 0/0/1", busy,
                               start_cyc.size() - b_start, done_cyc.size() - b_done); end
        checks++; if (frame_cnt !== 16'd0 || disp_buf !== 1'b0 || {phy_row, stream_row, stream_plane} !== 3'b0 || phy_oe_n !== 1'b1) begin
            errors++; $display("FAIL post_reset_vals: frames=%0d buf=%b ptr=%b oe_n=%b want 0/0/000/1", frame_cnt, disp_buf,
                               {phy_row, stream_row, stream_plane}, phy_oe_n); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_free_run();
        test_swap();
        test_short_shift();
        test_stop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
